// File: rtl/wcu_pkg.sv
// Shared types for the Julia worker control unit: per-lane state encoding
// and the upper bound on the number of lanes a pool may be built with.
package wcu_pkg;

  localparam int WCU_MAX_LANES = 16;

  typedef enum bit [2:0] {
    INIT       = 3'd0,
    ASK_WAIT   = 3'd1,
    CONVERT    = 3'd2,
    CALC1      = 3'd3,
    CALC2      = 3'd4,
    WRITE_WAIT = 3'd5
  } wcu_lane_state;

endpackage

// File: rtl/wcu_lane.sv
// One convert/calc lane sequencer. It waits for a grant, runs convert and
// then calc, and holds in WRITE_WAIT until the memory controller pops it.
// Optional watchdog (macro WCU_TIMEOUT_EN) forces CALC2 -> WRITE_WAIT after
// TIMEOUT_CYCLES cycles spent in calc and flags the entry as timed out.
module wcu_lane
  import wcu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          grant,
  input  logic          convert_done,
  input  logic          calc_done,
  input  logic          pop,
  output wcu_lane_state state,
  output logic          convert_start,
  output logic          calc_start,
  output logic          push
`ifdef WCU_TIMEOUT_EN
 ,output logic          timeout
`endif
);

  wcu_lane_state state_q, state_d;
  logic          tmo_hit;

`ifdef WCU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Calc-phase cycle counter: cleared on the way into CALC1, counts in CALC1/CALC2.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CONVERT && convert_done) begin
      cnt_d = '0;
    end else if (state_q == CALC1 || state_q == CALC2) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tmo_hit = (state_q == CALC2) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // A real calc_done in the expiry cycle takes precedence over the watchdog.
  assign timeout = tmo_hit && !calc_done;
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and Moore outputs of the lane FSM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    state_d       = state_q;
    convert_start = 1'b0;
    calc_start    = 1'b0;
    push          = 1'b0;
    case (state_q)
      INIT:       state_d = ASK_WAIT;
      ASK_WAIT:   if (grant) state_d = CONVERT;
      CONVERT: begin
        convert_start = 1'b1;
        if (convert_done) state_d = CALC1;
      end
      CALC1: begin
        calc_start = 1'b1;
        state_d    = CALC2;
      end
      CALC2: begin
        calc_start = 1'b1;
        if (calc_done || tmo_hit) begin
          push    = 1'b1;
          state_d = WRITE_WAIT;
        end
      end
      WRITE_WAIT: begin
        calc_start = 1'b1;
        if (pop) state_d = ASK_WAIT;
      end
      default:    state_d = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!n_rst) state_q <= INIT;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/wcu_pool.sv
// Multi-lane Julia worker control unit: hands jobs to free lanes with a
// rotating picker and returns finished lanes to the memory controller
// through an in-order completion FIFO.
// Optional watchdog: define WCU_TIMEOUT_EN to enable per-lane calc timeouts.
module wcu_pool
  import wcu_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int LANE_W         = ($clog2(NUM_LANES) > 0) ? $clog2(NUM_LANES) : 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 JW_start,
  output logic                 JW_ready,
  output logic [LANE_W-1:0]    JW_lane,
  output logic [NUM_LANES-1:0] convert_start,
  input  logic [NUM_LANES-1:0] convert_done,
  output logic [NUM_LANES-1:0] calc_start,
  input  logic [NUM_LANES-1:0] calc_done,
  output logic                 JW_done,
  output logic [LANE_W-1:0]    JW_done_lane,
  output logic                 JW_timeout,
  input  logic                 MC_done,
  output logic [LANE_W:0]      busy_count
);

  localparam int CNT_W = LANE_W + 1;

  wcu_lane_state        lane_state [NUM_LANES];
  logic [NUM_LANES-1:0] ask, grant, push, pop_vec;
  logic                 accept, pop;
  logic [LANE_W-1:0]    ptr_q, ptr_d, pick;
  logic [LANE_W-1:0]    fifo_lane_q [NUM_LANES];
  logic [LANE_W-1:0]    fifo_lane_d [NUM_LANES];
  logic [LANE_W-1:0]    rd_q, rd_d, wr_q, wr_d, wr_idx;
  logic [CNT_W-1:0]     cnt_q, cnt_d, n_push, busy_q, busy_d;
`ifdef WCU_TIMEOUT_EN
  logic [NUM_LANES-1:0] lane_tmo;
  logic                 fifo_tmo_q [NUM_LANES];
  logic                 fifo_tmo_d [NUM_LANES];
`endif

  function automatic logic [LANE_W-1:0] inc_wrap(input logic [LANE_W-1:0] v);
    return (v == LANE_W'(NUM_LANES - 1)) ? '0 : v + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign ask[i]     = (lane_state[i] == ASK_WAIT);
    assign grant[i]   = accept && (pick == LANE_W'(i));
    assign pop_vec[i] = pop && (JW_done_lane == LANE_W'(i));

    wcu_lane #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_lane (
      .clk          (clk),
      .n_rst        (n_rst),
      .grant        (grant[i]),
      .convert_done (convert_done[i]),
      .calc_done    (calc_done[i]),
      .pop          (pop_vec[i]),
      .state        (lane_state[i]),
      .convert_start(convert_start[i]),
      .calc_start   (calc_start[i]),
      .push         (push[i])
`ifdef WCU_TIMEOUT_EN
     ,.timeout      (lane_tmo[i])
`endif
    );
  end

  // Rotating picker: first ASK_WAIT lane at or above the pointer, wrapping.
  always_comb begin
    int idx;
    logic found;
    pick  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = (int'(ptr_q) + k) % NUM_LANES;
      if (!found && ask[LANE_W'(idx)]) begin
        pick  = LANE_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign JW_ready = |ask;
  assign JW_lane  = pick;
  assign accept   = JW_ready && JW_start;
  assign ptr_d    = accept ? inc_wrap(pick) : ptr_q;

  assign JW_done      = (cnt_q != '0);
  assign JW_done_lane = JW_done ? fifo_lane_q[rd_q] : '0;
  assign pop          = MC_done && JW_done;
`ifdef WCU_TIMEOUT_EN
  assign JW_timeout   = JW_done && fifo_tmo_q[rd_q];
`else
  assign JW_timeout   = 1'b0;
`endif

  // Completion FIFO update: simultaneous pushes land in ascending lane order.
  always_comb begin
    fifo_lane_d = fifo_lane_q;
`ifdef WCU_TIMEOUT_EN
    fifo_tmo_d  = fifo_tmo_q;
`endif
    wr_idx = wr_q;
    n_push = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) begin
        fifo_lane_d[wr_idx] = LANE_W'(i);
`ifdef WCU_TIMEOUT_EN
        fifo_tmo_d[wr_idx]  = lane_tmo[i];
`endif
        wr_idx = inc_wrap(wr_idx);
        n_push = n_push + 1'b1;
      end
    end
    wr_d  = wr_idx;
    rd_d  = pop ? inc_wrap(rd_q) : rd_q;
    cnt_d = cnt_q + n_push - CNT_W'(pop);
  end

  // Busy lanes as they will be after this edge, so busy_count tracks the states.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (lane_state[i])
        ASK_WAIT:               if (grant[i]) busy_d = busy_d + 1'b1;
        CONVERT, CALC1, CALC2:  busy_d = busy_d + 1'b1;
        WRITE_WAIT:             if (!pop_vec[i]) busy_d = busy_d + 1'b1;
        default:                busy_d = busy_d;
      endcase
    end
  end

  // Control registers: picker pointer, FIFO pointers/count, busy count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count gates every read and
    // JW_done_lane is forced to 0 while empty, so stale contents never escape.
    fifo_lane_q <= fifo_lane_d;
`ifdef WCU_TIMEOUT_EN
    fifo_tmo_q  <= fifo_tmo_d;
`endif
  end

  assign busy_count = busy_q;

endmodule
